// File: rtl/rr_mux4.sv
// rtl/rr_mux4.sv - 4-to-1 round-robin stream multiplexer with registered output
//
// Purpose:
//   Merges four valid/ready input channels onto one output channel. A rotating
//   priority pointer picks the next channel, and the chosen word is captured in a
//   single output register. The register is tagged with its source index on s1/s0
//   so that a downstream 4-way demux can route the word back.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   i0..i3         channel data (WIDTH bits each)
//   v0..v3         channel valid
//   r0..r3         channel ready (at most one is high in a cycle)
//   y              output data (registered)
//   y_valid        output valid (registered)
//   y_ready        downstream ready
//   s1, s0         source channel index of y, MSB/LSB (registered)

module rr_mux4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic             v0,
    input  logic             v1,
    input  logic             v2,
    input  logic             v3,
    output logic             r0,
    output logic             r1,
    output logic             r2,
    output logic             r3,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             s1,
    output logic             s0
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_y;
    logic [1:0]       r_src;
    logic [1:0]       r_ptr;

    logic [3:0]       w_v;
    logic             w_load_en;
    logic             w_any;
    logic [1:0]       w_grant;
    logic [1:0]       w_idx;
    logic             w_take;
    logic [WIDTH-1:0] w_data;

    assign w_v = {v3, v2, v1, v0};

    // The output register can accept a new word when it is empty or is being
    // drained this cycle; y_ready only feeds the load decision, never y itself.
    assign w_load_en = (r_state == ST_EMPTY) || y_ready;

    // Rotating-priority search. Walking from the farthest offset down to ptr
    // leaves the closest asserted channel as the final assignment.
    always_comb begin
        w_any   = 1'b0;
        w_grant = r_ptr;
        w_idx   = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (w_v[w_idx]) begin
                w_any   = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    // Ready is suppressed during reset so nothing is consumed while the
    // output register is being cleared.
    assign w_take = w_load_en && w_any && !rst;

    assign r0 = w_take && (w_grant == 2'd0);
    assign r1 = w_take && (w_grant == 2'd1);
    assign r2 = w_take && (w_grant == 2'd2);
    assign r3 = w_take && (w_grant == 2'd3);

    always_comb begin
        w_data = i0;
        case (w_grant)
            2'd0:    w_data = i0;
            2'd1:    w_data = i1;
            2'd2:    w_data = i2;
            default: w_data = i3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_y     <= '0;
            r_src   <= 2'd0;
            r_ptr   <= 2'd0;
        end else if (w_load_en) begin
            if (w_any) begin
                r_state <= ST_FULL;
                r_y     <= w_data;
                r_src   <= w_grant;
                // Granted channel drops to lowest priority; 2-bit add wraps 3 -> 0.
                r_ptr   <= w_grant + 2'd1;
            end else begin
                // Nothing to load: go empty but keep the last data and tag.
                r_state <= ST_EMPTY;
            end
        end
    end

    assign y       = r_y;
    assign y_valid = (r_state == ST_FULL);
    assign s1      = r_src[1];
    assign s0      = r_src[0];

endmodule

// File: tb/tb_rr_mux4.sv
// tb/tb_rr_mux4.sv - self-checking bench for rr_mux4 (vector table plus randomized model)

module tb_rr_mux4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i0, i1, i2, i3;
    logic       v0, v1, v2, v3;
    logic       r0, r1, r2, r3;
    logic [7:0] y;
    logic       y_valid;
    logic       y_ready;
    logic       s1, s0;

    always #5 clk = ~clk;

    rr_mux4 #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3),
        .v0(v0), .v1(v1), .v2(v2), .v3(v3),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3),
        .y(y), .y_valid(y_valid), .y_ready(y_ready),
        .s1(s1), .s0(s0)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] base;   // i_k = base + k
        logic       rst;
        logic [3:0] v;
        logic       yr;
        logic       yv;     // expected outputs seen during this cycle
        logic [7:0] y;
        logic [1:0] s;
        logic [3:0] r;
    } vec_t;

    localparam int NV = 34;
    vec_t tbl[NV];

    function automatic vec_t mk(input logic [7:0] b, input logic rs, input logic [3:0] v,
                                input logic yr, input logic yv, input logic [7:0] ey,
                                input logic [1:0] es, input logic [3:0] er);
        vec_t t;
        t.base = b; t.rst = rs; t.v = v; t.yr = yr;
        t.yv = yv; t.y = ey; t.s = es; t.r = er;
        return t;
    endfunction

    task automatic drive(input logic rs, input logic [3:0] v, input logic yr,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3);
        rst = rs; {v3, v2, v1, v0} = v; y_ready = yr;
        i0 = d0; i1 = d1; i2 = d2; i3 = d3;
    endtask

    // Randomized-phase reference state
    int         m_ptr;
    bit         m_yv;
    logic [7:0] m_y;
    int         m_s;
    bit         pend[4];
    logic [7:0] dat[4];

    initial begin
        // Reset check (A0..A3), round-robin, drain, sparse wrap, backpressure, reset mid-op
        tbl[0]  = mk(8'hA0, 1, 4'hF, 1, 0, 8'h00, 0, 4'b0000);
        tbl[1]  = mk(8'hA0, 1, 4'hF, 1, 0, 8'h00, 0, 4'b0000);
        tbl[2]  = mk(8'hA0, 0, 4'hF, 1, 0, 8'h00, 0, 4'b0001);
        tbl[3]  = mk(8'h10, 1, 4'hF, 1, 1, 8'hA0, 0, 4'b0000);
        tbl[4]  = mk(8'h10, 0, 4'hF, 1, 0, 8'h00, 0, 4'b0001);
        tbl[5]  = mk(8'h10, 0, 4'hF, 1, 1, 8'h10, 0, 4'b0010);
        tbl[6]  = mk(8'h10, 0, 4'hF, 1, 1, 8'h11, 1, 4'b0100);
        tbl[7]  = mk(8'h10, 0, 4'hF, 1, 1, 8'h12, 2, 4'b1000);
        tbl[8]  = mk(8'h10, 0, 4'hF, 1, 1, 8'h13, 3, 4'b0001);
        tbl[9]  = mk(8'h10, 0, 4'hF, 1, 1, 8'h10, 0, 4'b0010);
        tbl[10] = mk(8'h10, 0, 4'hF, 1, 1, 8'h11, 1, 4'b0100);
        tbl[11] = mk(8'h10, 0, 4'hF, 1, 1, 8'h12, 2, 4'b1000);
        tbl[12] = mk(8'h10, 0, 4'h0, 1, 1, 8'h13, 3, 4'b0000);
        tbl[13] = mk(8'h10, 0, 4'h0, 1, 0, 8'h13, 3, 4'b0000);
        tbl[14] = mk(8'h10, 0, 4'h5, 1, 0, 8'h13, 3, 4'b0001);
        tbl[15] = mk(8'h10, 0, 4'h5, 1, 1, 8'h10, 0, 4'b0100);
        tbl[16] = mk(8'h10, 0, 4'h5, 1, 1, 8'h12, 2, 4'b0001);
        tbl[17] = mk(8'h10, 0, 4'h5, 1, 1, 8'h10, 0, 4'b0100);
        tbl[18] = mk(8'h10, 0, 4'h2, 1, 1, 8'h12, 2, 4'b0010);
        tbl[19] = mk(8'h10, 0, 4'h0, 1, 1, 8'h11, 1, 4'b0000);
        tbl[20] = mk(8'h10, 0, 4'h3, 1, 0, 8'h11, 1, 4'b0001);
        tbl[21] = mk(8'h10, 0, 4'h0, 1, 1, 8'h10, 0, 4'b0000);
        tbl[22] = mk(8'h59, 0, 4'h2, 1, 0, 8'h10, 0, 4'b0010);
        tbl[23] = mk(8'h59, 0, 4'h8, 0, 1, 8'h5A, 1, 4'b0000);
        tbl[24] = mk(8'h59, 0, 4'h8, 0, 1, 8'h5A, 1, 4'b0000);
        tbl[25] = mk(8'h59, 0, 4'h8, 0, 1, 8'h5A, 1, 4'b0000);
        tbl[26] = mk(8'h59, 0, 4'h8, 1, 1, 8'h5A, 1, 4'b1000);
        tbl[27] = mk(8'h59, 0, 4'h0, 1, 1, 8'h5C, 3, 4'b0000);
        tbl[28] = mk(8'h59, 0, 4'h1, 1, 0, 8'h5C, 3, 4'b0001);
        tbl[29] = mk(8'h59, 0, 4'h0, 0, 1, 8'h59, 0, 4'b0000);
        tbl[30] = mk(8'h59, 1, 4'h0, 0, 1, 8'h59, 0, 4'b0000);
        tbl[31] = mk(8'h59, 0, 4'h5, 1, 0, 8'h00, 0, 4'b0001);
        tbl[32] = mk(8'h59, 0, 4'h0, 1, 1, 8'h59, 0, 4'b0000);
        tbl[33] = mk(8'h59, 0, 4'h3, 1, 0, 8'h59, 0, 4'b0010);

        drive(1, 4'hF, 1, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
        @(posedge clk); #1;

        for (int n = 0; n < NV; n++) begin
            drive(tbl[n].rst, tbl[n].v, tbl[n].yr, tbl[n].base, tbl[n].base + 8'd1,
                  tbl[n].base + 8'd2, tbl[n].base + 8'd3);
            @(negedge clk);
            chk($sformatf("vec%0d y_valid", n), 32'(y_valid), 32'(tbl[n].yv));
            chk($sformatf("vec%0d y", n), 32'(y), 32'(tbl[n].y));
            chk($sformatf("vec%0d s1s0", n), 32'({s1, s0}), 32'(tbl[n].s));
            chk($sformatf("vec%0d ready", n), 32'({r3, r2, r1, r0}), 32'(tbl[n].r));
            @(posedge clk); #1;
        end

        // Randomized phase: start from a known reset.
        drive(1, 4'h0, 1, 8'h00, 8'h00, 8'h00, 8'h00);
        @(posedge clk); #1;
        m_ptr = 0; m_yv = 0; m_y = 8'h00; m_s = 0;
        for (int k = 0; k < 4; k++) begin pend[k] = 0; dat[k] = 8'h00; end

        for (int c = 0; c < 3000; c++) begin
            bit         rs;
            bit         yr;
            bit         load;
            int         g;
            logic [3:0] vv;
            logic [3:0] er;
            rs = ($urandom_range(0, 39) == 0);
            yr = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) begin
                if (!pend[k] && ($urandom_range(0, 1) == 1)) begin
                    pend[k] = 1;
                    dat[k]  = 8'($urandom);
                end
                vv[k] = pend[k];
            end
            drive(rs, vv, yr, dat[0], dat[1], dat[2], dat[3]);

            load = !m_yv || yr;
            g = -1;
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && pend[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            end
            er = (!rs && load && g >= 0) ? 4'(1 << g) : 4'b0000;

            @(negedge clk);
            chk("rnd y_valid", 32'(y_valid), 32'(m_yv));
            chk("rnd y", 32'(y), 32'(m_y));
            chk("rnd s1s0", 32'({s1, s0}), 32'(m_s));
            chk("rnd ready", 32'({r3, r2, r1, r0}), 32'(er));

            if (rs) begin
                m_yv = 0; m_y = 8'h00; m_s = 0; m_ptr = 0;
            end else if (load) begin
                if (g >= 0) begin
                    m_y = dat[g]; m_s = g; m_yv = 1; m_ptr = (g + 1) % 4;
                    pend[g] = 0;
                end else begin
                    m_yv = 0;
                end
            end
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
